// File: rtl/ppl_ctrl.sv
// ppl_ctrl: pipeline sequencer for the interrupt-capable 5-stage core.
// Merges memory stalls, branch holds, EX redirects and interrupt entry/return
// into one hold/jump/flush set, and owns the saved return address (epc).
module ppl_ctrl #(
  parameter int                 ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]  INT_VECTOR = 32'h0000_0100,
  parameter int                 DRAIN_CYC  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic              hold_pc_req,
  input  logic              ex_br_done,
  input  logic              ex_jump_flag,
  input  logic [ADDR_W-1:0] ex_jump_pc,
  input  logic              mem_stall,
  input  logic              irq,
  input  logic              int_en,
  input  logic              ex_iret,
  output logic [1:0]        hold_flag,
  output logic              jump_flag,
  output logic [ADDR_W-1:0] jump_pc,
  output logic              flush,
  output logic              int_ack,
  output logic              in_isr,
  output logic [ADDR_W-1:0] epc
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BR_WAIT   = 2'd1,
    INT_DRAIN = 2'd2,
    INT_JUMP  = 2'd3
  } state_t;

  localparam logic [1:0] HOLD_NONE = 2'b00;
  localparam logic [1:0] HOLD_PC   = 2'b01;
  localparam logic [1:0] HOLD_PPL  = 2'b10;

  // The drain counter counts down to zero, so it is loaded with one less than
  // the number of drain cycles; DRAIN_CYC=1 therefore loads zero.
  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYC - 1);

  state_t            state_q, state_d;
  logic [3:0]        drain_cnt_q, drain_cnt_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic              in_isr_q, in_isr_d;

  // Arbitrate all requests for this cycle and compute the next register values.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    epc_d       = epc_q;
    in_isr_d    = in_isr_q;
    hold_flag   = HOLD_NONE;
    jump_flag   = 1'b0;
    jump_pc     = '0;
    flush       = 1'b0;
    int_ack     = 1'b0;

    if (!rst) begin
      if (mem_stall) begin
        // Whole pipeline frozen; any redirect is re-presented by EX later.
        hold_flag = HOLD_PPL;
      end else if (ex_iret && in_isr_q) begin
        jump_flag = 1'b1;
        jump_pc   = epc_q;
        flush     = 1'b1;
        in_isr_d  = 1'b0;
        state_d   = IDLE;
      end else begin
        if (ex_jump_flag) begin
          jump_flag = 1'b1;
          jump_pc   = ex_jump_pc;
          flush     = 1'b1;
        end

        unique case (state_q)
          IDLE: begin
            // A redirect makes the fetched instruction stale, so neither a
            // branch hold nor an interrupt entry is started on top of it.
            if (!ex_jump_flag) begin
              if (hold_pc_req) begin
                hold_flag = HOLD_PC;
                state_d   = BR_WAIT;
              end else if (irq && int_en && !in_isr_q) begin
                state_d     = INT_DRAIN;
                epc_d       = if_pc;
                drain_cnt_d = DRAIN_INIT;
              end
            end
          end

          BR_WAIT: begin
            if (ex_br_done) begin
              state_d = IDLE;
            end else begin
              hold_flag = HOLD_PC;
            end
          end

          INT_DRAIN: begin
            hold_flag = HOLD_PC;
            // A redirect resolved while draining becomes the return address.
            if (ex_jump_flag) begin
              epc_d = ex_jump_pc;
            end
            if (drain_cnt_q == 4'd0) begin
              state_d = INT_JUMP;
            end else begin
              drain_cnt_d = drain_cnt_q - 4'd1;
            end
          end

          INT_JUMP: begin
            // The vector wins over a coincident redirect, whose target is
            // kept as the return address instead.
            if (ex_jump_flag) begin
              epc_d = ex_jump_pc;
            end
            jump_flag = 1'b1;
            jump_pc   = INT_VECTOR;
            flush     = 1'b1;
            int_ack   = 1'b1;
            in_isr_d  = 1'b1;
            state_d   = IDLE;
          end

          default: state_d = IDLE;
        endcase
      end
    end
  end

  // State, drain counter, return address and handler flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      drain_cnt_q <= 4'd0;
      epc_q       <= '0;
      in_isr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      epc_q       <= epc_d;
      in_isr_q    <= in_isr_d;
    end
  end

  assign in_isr = in_isr_q;
  assign epc    = epc_q;

endmodule
